mine_placer: RTL and testbench
==============================

// Module: mine_placer
// PURPOSE
//  Generates the 6x6 minesweeper board: places MINES mines at pseudo-random cells.
//  The player's first-click cell and its neighbours are kept mine-free.
//  Drives the 36-bit cell_mine vector consumed by the neighbour-count logic.
//  Runs once per game, on start, after the first click is known.
// PARAMETERS
//  MINES     8         mines to place; legal range 1..27 (36 minus a full 3x3 safe zone)
//  LFSR_INIT 16'hACE1  LFSR reset value; also replaces any loaded seed of 0
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   reset; asynchronous, active-high (asserted = 1)
//  seed_load  in   1   load seed into LFSR; honoured only in IDLE
//  seed       in   16  LFSR seed value
//  start      in   1   begin placement; honoured only in IDLE (ignored while busy)
//  safe_pos   in   6   first-click index (row*6+col); 36..63 = no safe zone
//  busy       out  1   high from the cycle after start until done
//  done       out  1   one-cycle pulse when placement is complete
//  cell_mine  out  36  bit i = mine at index i; held stable outside busy
//  mine_count out  6   mines placed so far; equals MINES when done
// BEHAVIOUR
//  Reset values: cell_mine=0, mine_count=0, busy=0, done=0, LFSR=LFSR_INIT, state=IDLE.
//  LFSR
//   - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift left, feedback into bit0.
//   - Advances every cycle in every state except the cycle of a seed load.
//   - seed_load in IDLE: LFSR <= (seed==0) ? LFSR_INIT : seed.
//   - If seed_load and start are both high in IDLE: the seed loads that cycle; start is still honoured.
//  FSM: IDLE -> CLEAR -> DRAW -> DONE -> IDLE.
//   - IDLE:  start=1 -> CLEAR. Latch safe_pos internally, so later changes to the input are ignored.
//   - CLEAR: cell_mine <= 0, mine_count <= 0, busy <= 1 (busy visible the cycle after start).
//   - DRAW:  one candidate per cycle, cand = LFSR[5:0].
//       Reject if any of: cand >= 36; cand already a mine; cand in the safe zone.
//       Otherwise set cell_mine[cand] and increment mine_count.
//       When the accepted mine makes mine_count == MINES -> DONE.
//   - DONE:  busy <= 0, done <= 1 for exactly one cycle -> IDLE.
//  Safe zone
//   - Cells with |row-row_s| <= 1 and |col-col_s| <= 1; row = idx/6, col = idx%6.
//   - No wrap across row or board edges: e.g. safe_pos=5 protects 4,5,10,11 only.
//   - row/col come from a constant 36-entry lookup or a compare chain. No divider.
//  Termination: a maximal-period LFSR visits all 64 values of [5:0]; with MINES <= 27,
//   placement completes in under 2^16 * MINES cycles (typically < 4*MINES).
//  cell_mine holds its final value until the next start. Clearing happens only in CLEAR.
//  Reset mid-operation: all outputs take their reset values immediately; the FSM goes to IDLE.
//  MINES outside 1..27 is a configuration error: flag it with an elaboration-time check.
// TESTING
//  1. Reset, start with safe_pos=0 and MINES=8 -> done pulses once. Then check:
//     popcount(cell_mine)=8, mine_count=8, bits 0,1,6,7 all 0,
//     and cell_mine matches a bit-exact C model from LFSR 16'hACE1.
//  2. safe_pos=14 -> bits 7,8,9,13,14,15,19,20,21 = 0, popcount 8.
//     Repeat with safe_pos=5: bits 4,5,10,11 = 0, and bit 6 may be 1 (no wrap).
//  3. seed_load with seed=0, then start -> result identical to test 1 (seed 0 maps to LFSR_INIT).
//     seed=16'h1234 -> matches the model for that seed.
//  4. Pulse start again while busy -> ignored: a single done pulse, busy never drops early.
//  5. Assert rst_n mid-DRAW -> next edge: cell_mine=0, mine_count=0, busy=0, done=0.
//     A new start then completes normally.
//  6. safe_pos=40 with MINES=27 -> no exclusion, popcount 27, completes, and done is followed by IDLE.

Source files
------------

// File: rtl/mine_placer.sv
// Purpose: places MINES mines on a 6x6 board from a 16-bit LFSR, keeping the first-click 3x3 zone clear.
// Latency: busy the cycle after start, one clear cycle, then one candidate per cycle until MINES accepted; done pulses once.
// Backpressure: none; start and seed_load are honoured only in IDLE and ignored while a placement runs.
module mine_placer #(
    parameter int          MINES     = 8,
    parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        start,
    input  logic [5:0]  safe_pos,
    output logic        busy,
    output logic        done,
    output logic [35:0] cell_mine,
    output logic [5:0]  mine_count
);

    // A board needs room for the mines outside a full 3x3 safe zone.
    if (MINES < 1 || MINES > 27) begin : g_bad_mines
        $error("mine_placer: MINES must be in 1..27");
    end

    localparam logic [5:0] MINES_W = 6'(MINES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [35:0] cell_mine_q, cell_mine_d;
    logic [5:0]  mine_count_q, mine_count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [5:0]  safe_q, safe_d;

    // Row of a board index via a compare chain (indices >= 36 land in row 5 and are rejected elsewhere).
    function automatic logic [2:0] row_of(input logic [5:0] idx);
        logic [2:0] r;
        if (idx < 6'd6)       r = 3'd0;
        else if (idx < 6'd12) r = 3'd1;
        else if (idx < 6'd18) r = 3'd2;
        else if (idx < 6'd24) r = 3'd3;
        else if (idx < 6'd30) r = 3'd4;
        else                  r = 3'd5;
        return r;
    endfunction

    // Column is the index minus six times its row; shifts and adds only.
    function automatic logic [2:0] col_of(input logic [5:0] idx);
        logic [2:0] r;
        logic [5:0] base;
        r    = row_of(idx);
        base = 6'({r, 2'b00}) + 6'({r, 1'b0});
        return 3'(idx - base);
    endfunction

    // True when two row (or column) coordinates differ by at most one.
    function automatic logic near(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] d;
        d = {1'b0, a} - {1'b0, b};
        return (d == 4'h0) || (d == 4'h1) || (d == 4'hF);
    endfunction

    logic [15:0] lfsr_step;
    logic [5:0]  cand;
    logic [35:0] cand_bit;
    logic        cand_ok;

    // Candidate evaluation: on the board, not yet a mine, and outside the protected zone.
    always_comb begin
        lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        cand      = lfsr_q[5:0];
        cand_bit  = 36'd1 << cand;
        cand_ok   = (cand < 6'd36)
                  && ((cell_mine_q & cand_bit) == 36'd0)
                  && !((safe_q < 6'd36)
                       && near(row_of(cand), row_of(safe_q))
                       && near(col_of(cand), col_of(safe_q)));
    end

    // Next-state logic: LFSR free-runs except on a seed load; FSM sequences clear, draw and done.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_step;
        cell_mine_d  = cell_mine_q;
        mine_count_d = mine_count_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        safe_d       = safe_q;
        case (state_q)
            S_IDLE: begin
                if (seed_load) begin
                    lfsr_d = (seed == 16'd0) ? LFSR_INIT : seed;
                end
                if (start) begin
                    safe_d  = safe_pos;
                    busy_d  = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cell_mine_d  = 36'd0;
                mine_count_d = 6'd0;
                state_d      = S_DRAW;
            end
            S_DRAW: begin
                if (cand_ok) begin
                    cell_mine_d  = cell_mine_q | cand_bit;
                    mine_count_d = mine_count_q + 6'd1;
                    if (mine_count_q + 6'd1 == MINES_W) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset asserted high.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            lfsr_q       <= LFSR_INIT;
            cell_mine_q  <= 36'd0;
            mine_count_q <= 6'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            safe_q       <= 6'd63;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cell_mine_q  <= cell_mine_d;
            mine_count_q <= mine_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            safe_q       <= safe_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign cell_mine  = cell_mine_q;
    assign mine_count = mine_count_q;

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: two instances (8 and 27 mines) share stimulus.
// A timeline model predicts each placement's board and length from the LFSR sequence.
// Outputs are compared on every falling edge, plus directed literal checks.
module tb_mine_placer;

    localparam logic [15:0] INIT = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seed_load;
    logic [15:0] seed;
    logic        start;
    logic [5:0]  safe_pos;

    logic        busy0, done0, busy1, done1;
    logic [35:0] cell0, cell1;
    logic [5:0]  cnt0, cnt1;

    int checks   = 0;
    int failures = 0;
    int dcnt0    = 0;
    int dcnt1    = 0;

    always #5 clk = ~clk;

    mine_placer #(.MINES(8), .LFSR_INIT(INIT)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .start(start),
        .safe_pos(safe_pos), .busy(busy0), .done(done0), .cell_mine(cell0), .mine_count(cnt0)
    );

    mine_placer #(.MINES(27), .LFSR_INIT(INIT)) u_dut27 (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .start(start),
        .safe_pos(safe_pos), .busy(busy1), .done(done1), .cell_mine(cell1), .mine_count(cnt1)
    );

    typedef struct packed {
        logic [35:0] board;
        logic [31:0] n;
    } place_t;

    function automatic int mines_of(input int i);
        return (i == 0) ? 8 : 27;
    endfunction

    function automatic logic [15:0] m_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] m_load(input logic [15:0] v, input logic ld, input logic [15:0] sd);
        if (ld) return (sd == 16'd0) ? INIT : sd;
        return m_step(v);
    endfunction

    function automatic logic [35:0] m_safe_mask(input int sp);
        logic [35:0] m;
        int dr, dc;
        m = '0;
        if (sp < 36) begin
            for (int idx = 0; idx < 36; idx++) begin
                dr = idx / 6 - sp / 6;
                dc = idx % 6 - sp % 6;
                if (dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1) m[idx] = 1'b1;
            end
        end
        return m;
    endfunction

    // Board and number of draw cycles, given the LFSR value seen in the first draw cycle.
    function automatic place_t m_place(input logic [15:0] l0, input int sp, input int mines);
        place_t      r;
        logic [15:0] l;
        logic [35:0] mask;
        int          placed, c;
        r.board = '0;
        r.n     = '0;
        l       = l0;
        placed  = 0;
        mask    = m_safe_mask(sp);
        for (int k = 0; k < 70000 && placed < mines; k++) begin
            c   = int'(l[5:0]);
            r.n = r.n + 32'd1;
            if (c < 36) begin
                if (!r.board[c] && !mask[c]) begin
                    r.board[c] = 1'b1;
                    placed++;
                end
            end
            l = m_step(l);
        end
        return r;
    endfunction

    logic [15:0] m_lfsr [2];
    int          m_rem  [2];
    logic [35:0] m_board[2];
    int          m_mc   [2];
    place_t      m_pl   [2];

    // Result a start accepted at the coming edge would produce (one clear cycle precedes drawing).
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            m_pl[i] = m_place(m_step(m_load(m_lfsr[i], seed_load, seed)), int'(safe_pos), mines_of(i));
        end
    end

    // Model timeline: m_rem counts clear + draw + done cycles still ahead.
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_lfsr[i]  <= INIT;
                m_rem[i]   <= 0;
                m_board[i] <= '0;
                m_mc[i]    <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_rem[i] == 0) begin
                    m_lfsr[i] <= m_load(m_lfsr[i], seed_load, seed);
                    if (start) begin
                        m_rem[i]   <= int'(m_pl[i].n) + 2;
                        m_board[i] <= m_pl[i].board;
                        m_mc[i]    <= mines_of(i);
                    end
                end else begin
                    m_lfsr[i] <= m_step(m_lfsr[i]);
                    m_rem[i]  <= m_rem[i] - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("busy8", 64'(busy0), 64'(m_rem[0] >= 2));
        chk("done8", 64'(done0), 64'(m_rem[0] == 1));
        chk("busy27", 64'(busy1), 64'(m_rem[1] >= 2));
        chk("done27", 64'(done1), 64'(m_rem[1] == 1));
        if (m_rem[0] < 2) begin
            chk("board8", 64'(cell0), 64'(m_board[0]));
            chk("count8", 64'(cnt0), 64'(m_mc[0]));
        end
        if (m_rem[1] < 2) begin
            chk("board27", 64'(cell1), 64'(m_board[1]));
            chk("count27", 64'(cnt1), 64'(m_mc[1]));
        end
        if (done0) dcnt0++;
        if (done1) dcnt1++;
    end

    task automatic pulse_start(input logic [5:0] sp, input logic ld, input logic [15:0] sd);
        @(posedge clk); #2;
        safe_pos  = sp;
        start     = 1'b1;
        seed_load = ld;
        seed      = sd;
        @(posedge clk); #2;
        start     = 1'b0;
        seed_load = 1'b0;
        safe_pos  = sp ^ 6'h2A;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(posedge clk); #1;
            if (m_rem[0] == 0 && m_rem[1] == 0 && !busy0 && !busy1 && !done0 && !done1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s timeout busy8=%0d busy27=%0d required idle", name, busy0, busy1);
        end
        @(negedge clk);
    endtask

    logic [35:0] board_a;
    int          d0_before, d1_before;

    initial begin
        rst_n     = 1'b1;
        seed_load = 1'b0;
        seed      = 16'd0;
        start     = 1'b0;
        safe_pos  = 6'd0;

        // Pin the model with hand-derived values.
        chk("model_step_ace1", 64'(m_step(16'hACE1)), 64'h59C3);
        chk("model_mask0", 64'(m_safe_mask(0)), 64'hC3);
        chk("model_mask5", 64'(m_safe_mask(5)), 64'hC30);
        chk("model_mask14", 64'(m_safe_mask(14)), 64'h38E380);
        chk("model_mask40", 64'(m_safe_mask(40)), 64'h0);

        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_cell", 64'(cell0), 64'h0);
        chk("rst_count", 64'(cnt0), 64'h0);
        chk("rst_busy", 64'(busy0), 64'h0);
        chk("rst_done", 64'(done0), 64'h0);

        // 1: first click at 0.
        d0_before = dcnt0;
        pulse_start(6'd0, 1'b0, 16'd0);
        wait_idle("t1_wait");
        chk("t1_pop", 64'($countones(cell0)), 64'd8);
        chk("t1_count", 64'(cnt0), 64'd8);
        chk("t1_safe", 64'(cell0 & 36'hC3), 64'h0);
        chk("t1_pop27", 64'($countones(cell1)), 64'd27);
        chk("t1_safe27", 64'(cell1 & 36'hC3), 64'h0);
        chk("t1_done_pulses", 64'(dcnt0 - d0_before), 64'd1);

        // 2: interior and edge safe zones.
        pulse_start(6'd14, 1'b0, 16'd0);
        wait_idle("t2a_wait");
        chk("t2a_safe", 64'(cell0 & 36'h38E380), 64'h0);
        chk("t2a_pop", 64'($countones(cell0)), 64'd8);
        chk("t2a_safe27", 64'(cell1 & 36'h38E380), 64'h0);
        pulse_start(6'd5, 1'b0, 16'd0);
        wait_idle("t2b_wait");
        chk("t2b_safe", 64'(cell0 & 36'hC30), 64'h0);
        chk("t2b_pop", 64'($countones(cell0)), 64'd8);

        // 3: seed 0 maps to the reset value; explicit seed follows the model.
        pulse_start(6'd0, 1'b1, INIT);
        wait_idle("t3a_wait");
        board_a = cell0;
        pulse_start(6'd0, 1'b1, 16'd0);
        wait_idle("t3b_wait");
        chk("t3_seed0_same", 64'(cell0), 64'(board_a));
        pulse_start(6'd0, 1'b1, 16'h1234);
        wait_idle("t3c_wait");
        chk("t3_1234_pop", 64'($countones(cell0)), 64'd8);

        // 4: start pulses while busy are ignored.
        d0_before = dcnt0;
        d1_before = dcnt1;
        pulse_start(6'd14, 1'b0, 16'd0);
        repeat (2) @(posedge clk);
        #2 start = 1'b1; safe_pos = 6'd0;
        @(posedge clk); #2 start = 1'b0;
        wait_idle("t4_wait");
        chk("t4_done8", 64'(dcnt0 - d0_before), 64'd1);
        chk("t4_done27", 64'(dcnt1 - d1_before), 64'd1);
        chk("t4_safe", 64'(cell0 & 36'h38E380), 64'h0);

        // 5: reset during drawing.
        pulse_start(6'd0, 1'b0, 16'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("t5_async_busy", 64'(busy0), 64'h0);
        chk("t5_async_cell", 64'(cell0), 64'h0);
        @(negedge clk);
        chk("t5_cell", 64'(cell0), 64'h0);
        chk("t5_count", 64'(cnt0), 64'h0);
        chk("t5_busy", 64'(busy0), 64'h0);
        chk("t5_done", 64'(done0), 64'h0);
        chk("t5_busy27", 64'(busy1), 64'h0);
        @(posedge clk); #2 rst_n = 1'b0;
        pulse_start(6'd21, 1'b0, 16'd0);
        wait_idle("t5_wait");
        chk("t5_pop", 64'($countones(cell0)), 64'd8);
        chk("t5_count_end", 64'(cnt0), 64'd8);

        // 6: no safe zone, full 27-mine board.
        pulse_start(6'd40, 1'b0, 16'd0);
        wait_idle("t6_wait");
        chk("t6_pop27", 64'($countones(cell1)), 64'd27);
        chk("t6_count27", 64'(cnt1), 64'd27);
        repeat (2) @(negedge clk);
        chk("t6_idle_busy", 64'(busy1), 64'h0);
        chk("t6_idle_done", 64'(done1), 64'h0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
